fsm_lect_ram: RTL
=================

FSM_LECT_RAM -- requirements
Module: fsm_lect_ram

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- N_POS, 32, number of RAM positions (one-hot address width)
- W_DATO, 8, RAM data width
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- do_it_lect_ram  in  1  start request, sampled in REPOSO only
- inicio  in  5  first RAM position to read, captured at start
- cantidad  in  6  number of positions to read, captured at start; 0 means 32
- dato_ram  in  W_DATO  RAM read data, valid one cycle after address presented
- listo  in  1  consumer accepts dato_out when high with dato_valido
- dir_ram  out  N_POS  one-hot RAM address; all-zero when not reading
- r_ram_enable  out  1  RAM read enable
- w_ram_enable  out  1  RAM write enable; constant 0
- dato_out  out  W_DATO  captured word
- indice  out  5  position of the word in dato_out
- dato_valido  out  1  dato_out/indice valid
- ocupado  out  1  high in every state except REPOSO
- fin  out  1  one-cycle pulse after the last transfer

Function
REQ-003 States SHALL be REPOSO, DIR, CAPT, ENTREGA, FIN.
REQ-004 REPOSO: do_it_lect_ram=1 SHALL capture inicio into the position pointer and cantidad into the remaining counter, and move to DIR.
REQ-005 DIR: dir_ram SHALL be the one-hot of the pointer and r_ram_enable SHALL be 1; the next state is CAPT unconditionally.
REQ-006 CAPT: dir_ram and r_ram_enable SHALL hold the DIR values; at the end of the cycle dato_ram SHALL be latched into dato_out and the pointer into indice, and the FSM moves to ENTREGA.
REQ-007 ENTREGA: dato_valido SHALL be 1 and dir_ram=0 with r_ram_enable=0; dato_out and indice SHALL stay stable until listo=1 is sampled.
REQ-008 A transfer SHALL occur on the cycle where dato_valido=1 and listo=1; on that edge the remaining counter decrements and the pointer increments modulo 32 (31 wraps to 0).
REQ-009 After a transfer, if the remaining count was 1 the FSM SHALL go to FIN; otherwise it goes to DIR.
REQ-010 FIN: fin=1 for exactly one cycle, then REPOSO.
REQ-011 cantidad=0 SHALL be treated as 32, so the remaining counter is 6 bits and loads 32.
REQ-012 do_it_lect_ram SHALL be ignored outside REPOSO; no restart and no queueing.
REQ-013 Minimum cost SHALL be 3 cycles per word (DIR, CAPT, ENTREGA with listo=1), plus 1 FIN cycle.
REQ-014 listo held high outside ENTREGA SHALL have no effect.
REQ-015 All outputs SHALL be registered or decoded only from state/registers, never combinationally from listo or dato_ram.

Reset
REQ-016 reset=1 at a clock edge SHALL force REPOSO from any state, including mid-sweep, and abandon the sweep without asserting fin.
REQ-017 Reset values SHALL be: dir_ram=0, r_ram_enable=0, w_ram_enable=0, dato_out=0, indice=0, dato_valido=0, ocupado=0, fin=0, pointer=0, remaining=0.

Structure
REQ-018 A shared package SHALL hold the state encoding constants, N_POS=32, W_DATO=8 and the cantidad-zero-means-32 constant, for reuse by fsm_inic_ram-type blocks.
REQ-019 The 5-to-32 one-hot address generation SHALL be one sub-module, dec_onehot_5a32, with a 5-bit input, an enable input and a 32-bit output, where the output is all-zero when disabled.

Verification
REQ-020 Start with inicio=0, cantidad=3, RAM[0..2]=00h,00h,10h, and listo held 1 -> three words with indice 0,1,2 and data 00h,00h,10h; fin occurs 10 cycles after the start edge; dir_ram values are 0x1, 0x2, 0x4.
REQ-021 Wrap: inicio=30, cantidad=4 -> indices 30,31,0,1; dir_ram values 0x40000000, 0x80000000, 0x1, 0x2.
REQ-022 Backpressure: listo=0 for 5 cycles in the first ENTREGA -> dato_valido stays 1 with dato_out stable; one transfer occurs on the first listo=1, and there are no duplicate or skipped words.
REQ-023 cantidad=0 -> exactly 32 transfers with indices inicio..inicio+31 mod 32, then a single fin pulse.
REQ-024 reset asserted during CAPT of word 2 -> the next cycle shows all outputs at reset values, fin is never pulsed, and a new start proceeds normally.
REQ-025 do_it_lect_ram pulsed while ocupado=1 -> sweep count and indices are unchanged; w_ram_enable=0 throughout every test.

Source files
------------

// File: rtl/fsm_lect_ram_pkg.sv
// Shared constants and state encoding for the RAM sweep sequencers.
// Used by fsm_lect_ram and related fsm_inic_ram-style blocks.
package fsm_lect_ram_pkg;

  localparam int unsigned N_POS_DEF  = 32;
  localparam int unsigned W_DATO_DEF = 8;
  localparam int unsigned W_PTR      = 5;
  localparam int unsigned W_CNT      = 6;

  // A cantidad of zero requests a full sweep of every position.
  localparam logic [W_CNT-1:0] CANT_CERO = 6'd32;

  typedef enum logic [2:0] {
    REPOSO  = 3'd0,
    DIR     = 3'd1,
    CAPT    = 3'd2,
    ENTREGA = 3'd3,
    FIN     = 3'd4
  } estado_t;

endpackage

// File: rtl/fsm_lect_ram_dec.sv
// 5-to-32 one-hot decoder; output forced to zero when disabled.
module dec_onehot_5a32 (
  input  logic [4:0]  sel,
  input  logic        en,
  output logic [31:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/fsm_lect_ram.sv
// Sequential RAM reader: sweeps cantidad positions from inicio, one word
// at a time, handing each to a consumer with a valid/ready-style handshake.
module fsm_lect_ram
  import fsm_lect_ram_pkg::*;
#(
  parameter int unsigned N_POS  = N_POS_DEF,
  parameter int unsigned W_DATO = W_DATO_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              do_it_lect_ram,
  input  logic [4:0]        inicio,
  input  logic [5:0]        cantidad,
  input  logic [W_DATO-1:0] dato_ram,
  input  logic              listo,
  output logic [N_POS-1:0]  dir_ram,
  output logic              r_ram_enable,
  output logic              w_ram_enable,
  output logic [W_DATO-1:0] dato_out,
  output logic [4:0]        indice,
  output logic              dato_valido,
  output logic              ocupado,
  output logic              fin
);

  estado_t           estado, est_sig;
  logic [W_PTR-1:0]  ptr, ptr_sig;
  logic [W_CNT-1:0]  rem, rem_sig;
  logic              dir_en;
  logic [31:0]       onehot;

  assign w_ram_enable = 1'b0;

  // Next-state, pointer and remaining-count logic.
  always_comb begin
    est_sig = estado;
    ptr_sig = ptr;
    rem_sig = rem;
    case (estado)
      REPOSO: begin
        if (do_it_lect_ram) begin
          ptr_sig = inicio;
          rem_sig = (cantidad == '0) ? CANT_CERO : cantidad;
          est_sig = DIR;
        end
      end
      DIR:  est_sig = CAPT;
      CAPT: est_sig = ENTREGA;
      ENTREGA: begin
        if (listo) begin
          ptr_sig = W_PTR'(ptr + W_PTR'(1));
          rem_sig = W_CNT'(rem - W_CNT'(1));
          est_sig = (rem == W_CNT'(1)) ? FIN : DIR;
        end
      end
      FIN:     est_sig = REPOSO;
      default: est_sig = REPOSO;
    endcase
  end

  // Address is decoded from the upcoming state so dir_ram leaves a register.
  assign dir_en = (est_sig == DIR) || (est_sig == CAPT);

  dec_onehot_5a32 u_dec (
    .sel    (ptr_sig),
    .en     (dir_en),
    .onehot (onehot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado       <= REPOSO;
      ptr          <= '0;
      rem          <= '0;
      dir_ram      <= '0;
      r_ram_enable <= 1'b0;
      dato_out     <= '0;
      indice       <= '0;
      dato_valido  <= 1'b0;
      ocupado      <= 1'b0;
      fin          <= 1'b0;
    end else begin
      estado       <= est_sig;
      ptr          <= ptr_sig;
      rem          <= rem_sig;
      dir_ram      <= N_POS'(onehot);
      r_ram_enable <= dir_en;
      dato_valido  <= (est_sig == ENTREGA);
      ocupado      <= (est_sig != REPOSO);
      fin          <= (est_sig == FIN);
      // RAM data is valid during CAPT, one cycle after the address.
      if (estado == CAPT) begin
        dato_out <= dato_ram;
        indice   <= ptr;
      end
    end
  end

endmodule
